// File: rtl/video_regs_pkg.sv
// Shared register map, STAT bit positions and PPU mode encoding for the
// CPU-visible video register bank.
package video_regs_pkg;

  localparam int unsigned IDX_CTRL = 0;
  localparam int unsigned IDX_STAT = 1;
  localparam int unsigned IDX_SCY  = 2;
  localparam int unsigned IDX_SCX  = 3;
  localparam int unsigned IDX_LY   = 4;
  localparam int unsigned IDX_LYC  = 5;
  localparam int unsigned IDX_WY   = 6;
  localparam int unsigned IDX_WX   = 7;

  localparam int unsigned CTRL_LCD_EN = 7;

  localparam int unsigned STAT_LYC_EN = 6;
  localparam int unsigned STAT_OAM_EN = 5;
  localparam int unsigned STAT_VBL_EN = 4;
  localparam int unsigned STAT_HBL_EN = 3;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_XFER   = 2'd3
  } ppu_mode_t;

endpackage

// File: rtl/video_regs_bank_if.sv
// CPU data-bus bundle between the CPU and the video register bank.
// Handshake: a read is combinational and valid (cpu_rdata_oe) in the same
// cycle cpu_rd is high on a mapped address; a write commits on the rising
// clk edge where cpu_wr is high. The bank never stalls, so there is no ready.
interface video_regs_bank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rdata_oe;

  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
    input  cpu_rdata, cpu_rdata_oe
  );

  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
    output cpu_rdata, cpu_rdata_oe
  );
endinterface

// File: rtl/stat_irq_gen.sv
// STAT interrupt: ORs the enabled sources into one line and pulses on its
// rising edge only, so a source joining an already-high line is swallowed.
module stat_irq_gen
  import video_regs_pkg::*;
(
  input  logic      clk,
  input  logic      nreset,
  input  logic      lyc_eq,
  input  ppu_mode_t ppu_mode,
  input  logic      lcd_en,
  input  logic      en_lyc,
  input  logic      en_oam,
  input  logic      en_vbl,
  input  logic      en_hbl,
  output logic      stat_irq
);

  logic w_stat_line;
  logic w_mode_src;
  logic r_stat_prev;

  always_comb begin
    w_mode_src = 1'b0;
    case (ppu_mode)
      MODE_HBLANK: w_mode_src = en_hbl;
      MODE_VBLANK: w_mode_src = en_vbl;
      MODE_OAM:    w_mode_src = en_oam;
      default:     w_mode_src = 1'b0;
    endcase
    w_stat_line = (lyc_eq & en_lyc) | (lcd_en & w_mode_src);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_stat_prev <= 1'b0;
    end else begin
      r_stat_prev <= w_stat_line;
    end
  end

  assign stat_irq = w_stat_line & ~r_stat_prev;

endmodule

// File: rtl/video_regs_bank.sv
// CPU-visible bank of video control registers with per-register double
// buffering, LY==LYC coincidence flag and edge-detected STAT interrupt.
module video_regs_bank
  import video_regs_pkg::*;
#(
  parameter int                         NUM_REGS    = 8,
  parameter int                         DATA_W      = 8,
  parameter int                         ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]          BASE_ADDR   = 8'h40,
  parameter logic [NUM_REGS-1:0]        SHADOW_MASK = 8'b1100_1100,
  parameter logic [NUM_REGS-1:0]        RO_MASK     = 8'b0001_0000,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS  = '0
) (
  input  logic                         clk,
  input  logic                         nreset,
  video_regs_bank_if.slave             bus,
  input  logic [7:0]                   ly,
  input  logic [1:0]                   ppu_mode,
  input  logic                         line_start,
  output logic [NUM_REGS*DATA_W-1:0]   regs_live,
  output logic [NUM_REGS*DATA_W-1:0]   regs_active,
  output logic [NUM_REGS-1:0]          shadow_pending,
  output logic                         lyc_eq,
  output logic                         stat_irq
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] HI_ADDR = LO_ADDR + (ADDR_W+1)'(NUM_REGS);

  logic [ADDR_W:0] w_addr_ext;
  logic            w_hit;
  logic [IDX_W-1:0] w_idx;
  logic            w_oe;
  logic            w_lcd_en;
  logic [7:0]      w_lyc;
  logic            r_lyc_eq;

  assign w_addr_ext = {1'b0, bus.cpu_addr};
  assign w_hit      = (w_addr_ext >= LO_ADDR) && (w_addr_ext < HI_ADDR);
  assign w_idx      = IDX_W'(bus.cpu_addr - BASE_ADDR);
  assign w_oe       = bus.cpu_rd && w_hit;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic              w_sel;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] r_live;

    assign w_sel = bus.cpu_wr && w_hit && (w_idx == IDX_W'(gi)) && !RO_MASK[gi];

    // STAT low bits are status views, never storage the CPU can change.
    if (gi == IDX_STAT) begin : g_stat
      assign w_next = w_sel ? {bus.cpu_wdata[DATA_W-1:3], r_live[2:0]} : r_live;
    end else begin : g_plain
      assign w_next = w_sel ? bus.cpu_wdata : r_live;
    end

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        r_live <= RESET_VALS[gi*DATA_W +: DATA_W];
      end else begin
        r_live <= w_next;
      end
    end

    assign regs_live[gi*DATA_W +: DATA_W] = r_live;

    if (SHADOW_MASK[gi]) begin : g_shadow
      logic [DATA_W-1:0] r_active;
      logic              r_pending;

      // Loading w_next lets a write landing on line_start reach the PPU now.
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          r_active  <= RESET_VALS[gi*DATA_W +: DATA_W];
          r_pending <= 1'b0;
        end else begin
          if (line_start) begin
            r_active <= w_next;
          end
          r_pending <= line_start ? 1'b0 : (r_pending | w_sel);
        end
      end

      assign regs_active[gi*DATA_W +: DATA_W] = r_active;
      assign shadow_pending[gi]               = r_pending;
    end else begin : g_direct
      assign regs_active[gi*DATA_W +: DATA_W] = r_live;
      assign shadow_pending[gi]               = 1'b0;
    end
  end

  always_comb begin
    bus.cpu_rdata = '0;
    if (w_oe) begin
      if (w_idx == IDX_W'(IDX_LY)) begin
        bus.cpu_rdata = DATA_W'(ly);
      end else if (w_idx == IDX_W'(IDX_STAT)) begin
        bus.cpu_rdata = {regs_live[IDX_STAT*DATA_W+3 +: DATA_W-3], r_lyc_eq, ppu_mode};
      end else begin
        bus.cpu_rdata = regs_live[w_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.cpu_rdata_oe = w_oe;

  assign w_lcd_en = regs_live[IDX_CTRL*DATA_W + CTRL_LCD_EN];
  assign w_lyc    = regs_live[IDX_LYC*DATA_W +: 8];

  // Gated by the registered lcd_en, so the flag drops one cycle after it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_lyc_eq <= 1'b0;
    end else begin
      r_lyc_eq <= w_lcd_en && (ly == w_lyc);
    end
  end

  assign lyc_eq = r_lyc_eq;

  stat_irq_gen u_stat_irq_gen (
    .clk      (clk),
    .nreset   (nreset),
    .lyc_eq   (r_lyc_eq),
    .ppu_mode (ppu_mode_t'(ppu_mode)),
    .lcd_en   (w_lcd_en),
    .en_lyc   (regs_live[IDX_STAT*DATA_W + STAT_LYC_EN]),
    .en_oam   (regs_live[IDX_STAT*DATA_W + STAT_OAM_EN]),
    .en_vbl   (regs_live[IDX_STAT*DATA_W + STAT_VBL_EN]),
    .en_hbl   (regs_live[IDX_STAT*DATA_W + STAT_HBL_EN]),
    .stat_irq (stat_irq)
  );

endmodule

// File: tb/tb_video_regs_bank.sv
// Self-checking bench for video_regs_bank: reset read table, shadow/pending
// sequences, LYC coincidence, STAT interrupt blocking and async reset.
module tb_video_regs_bank;

  logic        clk = 1'b0;
  logic        nreset;
  logic [7:0]  ly;
  logic [1:0]  ppu_mode;
  logic        line_start;
  logic [63:0] regs_live;
  logic [63:0] regs_active;
  logic [7:0]  shadow_pending;
  logic        lyc_eq;
  logic        stat_irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] addr;
    logic       exp_oe;
    logic [7:0] exp_data;
  } rd_vec_t;

  rd_vec_t rst_tab[10];

  always #5 clk = ~clk;

  video_regs_bank_if #(.ADDR_W(8), .DATA_W(8)) bus();

  video_regs_bank #(
    .NUM_REGS    (8),
    .DATA_W      (8),
    .ADDR_W      (8),
    .BASE_ADDR   (8'h40),
    .SHADOW_MASK (8'b1100_1100),
    .RO_MASK     (8'b0001_0000),
    .RESET_VALS  (64'h0)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .bus            (bus),
    .ly             (ly),
    .ppu_mode       (ppu_mode),
    .line_start     (line_start),
    .regs_live      (regs_live),
    .regs_active    (regs_active),
    .shadow_pending (shadow_pending),
    .lyc_eq         (lyc_eq),
    .stat_irq       (stat_irq)
  );

  function automatic logic [7:0] sl(input logic [63:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
    bus.cpu_addr  = addr;
    bus.cpu_wdata = data;
    bus.cpu_wr    = 1'b1;
    tick();
    bus.cpu_wr    = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] addr, input logic exp_oe, input logic [7:0] exp_data);
    logic [8:0] e;
    exp_q.push_back({exp_oe, exp_data});
    bus.cpu_addr = addr;
    bus.cpu_rd   = 1'b1;
    #2;
    e = exp_q.pop_front();
    check($sformatf("read_%0h", addr), {bus.cpu_rdata_oe, bus.cpu_rdata}, e);
    bus.cpu_rd   = 1'b0;
  endtask

  initial begin
    int irq_cnt;
    int idx_map[5];
    int k;
    logic [7:0] d;
    logic [7:0] a;

    idx_map = '{2, 3, 5, 6, 7};
    nreset        = 1'b0;
    ly            = 8'h5A;
    ppu_mode      = 2'd2;
    line_start    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_wdata = '0;

    rst_tab[0] = '{8'h3F, 1'b0, 8'h00};
    rst_tab[1] = '{8'h40, 1'b1, 8'h00};
    rst_tab[2] = '{8'h41, 1'b1, 8'h02};
    rst_tab[3] = '{8'h42, 1'b1, 8'h00};
    rst_tab[4] = '{8'h43, 1'b1, 8'h00};
    rst_tab[5] = '{8'h44, 1'b1, 8'h5A};
    rst_tab[6] = '{8'h45, 1'b1, 8'h00};
    rst_tab[7] = '{8'h46, 1'b1, 8'h00};
    rst_tab[8] = '{8'h47, 1'b1, 8'h00};
    rst_tab[9] = '{8'h48, 1'b0, 8'h00};

    tick();
    tick();
    check("rst_live",    regs_live,      64'h0);
    check("rst_active",  regs_active,    64'h0);
    check("rst_pending", shadow_pending, 8'h00);
    check("rst_lyc_eq",  lyc_eq,         1'b0);
    check("rst_irq",     stat_irq,       1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      cpu_read(rst_tab[i].addr, rst_tab[i].exp_oe, rst_tab[i].exp_data);
    end

    tick();
    nreset   = 1'b1;
    ly       = 8'h44;
    ppu_mode = 2'd3;
    tick();

    // Mid-line SCX write stays pending until line_start
    cpu_write(8'h43, 8'h37);
    check("scx_live",    sl(regs_live, 3),   8'h37);
    check("scx_active",  sl(regs_active, 3), 8'h00);
    check("scx_pending", shadow_pending,     8'h08);
    tick();
    check("scx_pending_hold", shadow_pending, 8'h08);
    cpu_read(8'h43, 1'b1, 8'h37);
    tick();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("scx_active_ls",  sl(regs_active, 3), 8'h37);
    check("scx_pending_ls", shadow_pending,     8'h00);

    // WY write coincident with line_start
    line_start = 1'b1;
    cpu_write(8'h46, 8'h10);
    line_start = 1'b0;
    check("wy_active",  sl(regs_active, 6), 8'h10);
    check("wy_live",    sl(regs_live, 6),   8'h10);
    check("wy_pending", shadow_pending,     8'h00);
    cpu_write(8'h40, 8'h91);
    check("ctrl_active", sl(regs_active, 0), 8'h91);
    cpu_write(8'h48, 8'hAA);
    cpu_write(8'h3F, 8'hBB);
    cpu_write(8'h44, 8'h77);
    check("no_stray_write", regs_live, 64'h00_10_00_00_37_00_00_91);
    cpu_read(8'h44, 1'b1, 8'h44);

    // LYC coincidence and first STAT pulse
    cpu_write(8'h45, 8'h45);
    cpu_write(8'h41, 8'h40);
    cpu_write(8'h40, 8'h80);
    check("lyc_pre",  lyc_eq,   1'b0);
    check("irq_pre",  stat_irq, 1'b0);
    ly = 8'h45;
    #1;
    check("lyc_latency", lyc_eq, 1'b0);
    tick();
    check("lyc_set",  lyc_eq,   1'b1);
    check("irq_lyc",  stat_irq, 1'b1);
    tick();
    check("irq_one_cycle", stat_irq, 1'b0);
    ppu_mode = 2'd1;
    cpu_read(8'h41, 1'b1, 8'h45);
    tick();
    cpu_write(8'h41, 8'hFF);
    check("stat_low_ro", sl(regs_live, 1), 8'hF8);
    cpu_read(8'h41, 1'b1, 8'hFD);

    // Second source while the line is high gives no pulse
    irq_cnt = 0;
    ppu_mode = 2'd0;
    #1;
    if (stat_irq) irq_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (stat_irq) irq_cnt++;
    end
    check("irq_blocked", irq_cnt, 0);
    ly       = 8'h46;
    ppu_mode = 2'd3;
    tick();
    tick();
    check("lyc_drop", lyc_eq,   1'b0);
    check("irq_idle", stat_irq, 1'b0);
    ppu_mode = 2'd0;
    #1;
    check("irq_hblank", stat_irq, 1'b1);
    tick();
    check("irq_hblank_end", stat_irq, 1'b0);

    // lcd_en off forces lyc_eq low
    ly = 8'h45;
    tick();
    check("lyc_again", lyc_eq, 1'b1);
    cpu_write(8'h40, 8'h00);
    tick();
    check("lyc_lcd_off", lyc_eq, 1'b0);
    cpu_write(8'h40, 8'h80);
    tick();
    check("lyc_lcd_on", lyc_eq, 1'b1);

    // Async reset with a write pending
    cpu_write(8'h42, 8'h22);
    check("scy_pending", shadow_pending, 8'h04);
    nreset = 1'b0;
    #1;
    check("arst_live",    regs_live,      64'h0);
    check("arst_active",  regs_active,    64'h0);
    check("arst_pending", shadow_pending, 8'h00);
    check("arst_lyc",     lyc_eq,         1'b0);
    check("arst_irq",     stat_irq,       1'b0);
    cpu_read(8'h42, 1'b1, 8'h00);
    tick();
    nreset = 1'b1;
    tick();
    cpu_write(8'h44, 8'h77);
    check("ly_ro", sl(regs_live, 4), 8'h00);
    cpu_write(8'h42, 8'h22);
    check("post_rst_active", sl(regs_active, 2), 8'h00);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("post_rst_ls", sl(regs_active, 2), 8'h22);

    // Random read-after-write and unmapped reads
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 4);
      d = 8'($urandom_range(0, 255));
      cpu_write(8'(8'h40 + idx_map[k]), d);
      cpu_read(8'(8'h40 + idx_map[k]), 1'b1, d);
      a = 8'($urandom_range(8'h48, 8'hFF));
      cpu_read(a, 1'b0, 8'h00);
      tick();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_regs_bank.md
Name: video_regs_bank

Overview:
Parametrised successor to the fixed video register latches: a generic CPU-visible bank of NUM_REGS video control registers at BASE_ADDR.
- Selected registers are double-buffered (live copy written by CPU; active copy loaded at line start) so mid-line scroll writes take effect on the next line.
- Adds a registered LY==LYC coincidence flag, a STAT register and edge-detected STAT interrupt generation.
- Sits between the CPU data bus and the PPU fetch/pixel logic.

Parameters:
NUM_REGS, 8, number of registers; index = addr - BASE_ADDR
DATA_W, 8, register width
ADDR_W, 8, width of low address compared against BASE_ADDR
BASE_ADDR, 8'h40, address of index 0
SHADOW_MASK, 8'b1100_1100, per-index: 1 = double-buffered (SCY, SCX, WY, WX)
RO_MASK, 8'b0001_0000, per-index: 1 = CPU writes ignored (LY)
RESET_VALS, all zero, packed NUM_REGS*DATA_W reset image, index 0 in LSBs

Ports:
clk  in  1  system clock, rising edge
nreset  in  1  asynchronous active-low reset
cpu_addr  in  ADDR_W  low CPU address
cpu_rd  in  1  read strobe
cpu_wr  in  1  write strobe, sampled on clk
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, 0 when not driving
cpu_rdata_oe  out  1  read data valid/bus drive enable
ly  in  8  current line counter from PPU
ppu_mode  in  2  0 hblank, 1 vblank, 2 OAM scan, 3 transfer
line_start  in  1  one-cycle pulse at start of each line
regs_live  out  NUM_REGS*DATA_W  CPU-written values
regs_active  out  NUM_REGS*DATA_W  values the PPU uses
shadow_pending  out  NUM_REGS  shadowed reg written since last line_start
lyc_eq  out  1  registered coincidence flag
stat_irq  out  1  one-cycle interrupt request pulse

Behaviour:
- Fixed map: 0 CTRL, 1 STAT, 2 SCY, 3 SCX, 4 LY, 5 LYC, 6 WY, 7 WX. CTRL bit7 = lcd_en.
- hit = cpu_addr in [BASE_ADDR, BASE_ADDR+NUM_REGS).
- Write: on clk edge with cpu_wr && hit && !RO_MASK[idx], the live register takes cpu_wdata. STAT bits[2:0] are never written; only bits[7:3] update. Writes with cpu_wr && !hit have no effect.
- Read (combinational): cpu_rdata_oe = cpu_rd && hit.
  - LY index returns the ly input.
  - STAT returns {live[7:3], lyc_eq, ppu_mode}.
  - All other indices return the live value.
  - When !oe, rdata = 0.
- Active copy:
  - Non-shadowed index: active = live (same cycle as live).
  - Shadowed index: active loads live on a line_start cycle. If a write and line_start hit the same index in the same cycle, active loads cpu_wdata (write wins, no lost update).
- shadow_pending[i]:
  - Set by a write to shadowed i.
  - Cleared on line_start.
  - A write coincident with line_start leaves it 0.
  - Always 0 for non-shadowed i.
- lyc_eq: registered each clk = lcd_en && (ly == live[LYC]); one cycle latency. Forced 0 the cycle after lcd_en falls.
- STAT line (combinational, internal): (lyc_eq&stat[6]) | (mode0&stat[3]) | (mode1&stat[4]) | (mode2&stat[5]). Mode terms are gated by lcd_en.
- stat_irq: one-cycle pulse when the STAT line is 1 and stat_prev is 0; stat_prev <= STAT line every cycle. If a second source asserts while the line is already high, there is no new pulse (STAT blocking).
- Reset (async, nreset=0):
  - live = active = RESET_VALS.
  - shadow_pending = 0, lyc_eq = 0, stat_prev = 0, stat_irq = 0.
  - cpu_rdata_oe follows cpu_rd/hit combinationally even in reset; read data shows reset values.
- Reset released mid-line: the first line_start after release copies live to active as normal.

Decomposition:
- Package video_regs_pkg:
  - Register index localparams (IDX_CTRL..IDX_WX).
  - STAT bit positions (STAT_LYC_EN=6, STAT_OAM_EN=5, STAT_VBL_EN=4, STAT_HBL_EN=3).
  - ppu_mode_t enum {MODE_HBLANK, MODE_VBLANK, MODE_OAM, MODE_XFER}.
- Sub-module stat_irq_gen: inputs lyc_eq, ppu_mode, lcd_en, enable bits; owns stat_prev; outputs stat_irq.

Test Plan:
- Reset then read all 8 addresses -> rdata = RESET_VALS bytes (LY returns ly input, STAT low bits = {0, ppu_mode}); oe=1 only for 0x40–0x47. Reading 0x48 gives oe=0, rdata=0.
- Write SCX=0x37 mid-line -> regs_live[SCX]=0x37 next cycle, regs_active[SCX] unchanged, pending[3]=1. After line_start -> active=0x37, pending=0.
- Write WY=0x10 on the same cycle as line_start -> active[WY]=0x10 immediately, pending[6]=0. Write CTRL=0x91 -> active[CTRL]=0x91 with no line_start.
- CTRL=0x80, LYC=0x45, stat[6]=1, step ly 0x44→0x45 -> lyc_eq=1 one cycle later, stat_irq single pulse. Write STAT=0xFF -> STAT bits[2:0] still reflect lyc_eq/mode.
- lyc_eq high, stat[3]=1, ppu_mode→0 -> no second stat_irq. Drop lyc_eq and mode; re-enter mode 0 -> new pulse.
- Assert nreset low mid-transfer with pending set -> all state at reset values immediately, stat_irq=0. Writes to LY (0x44) -> ignored.
